// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master controller:
// command bit positions and sequencer states.
package i2c_pkg;

   localparam int CTRL_START = 0;
   localparam int CTRL_STOP  = 1;
   localparam int CTRL_WRITE = 2;
   localparam int CTRL_READ  = 3;
   localparam int CTRL_NACK  = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BIT   = 3'd2,
      ST_ACK   = 3'd3,
      ST_STOP  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command/status and open-drain line bundle between the
// register block (master) and the I2C controller (slave).
interface i2c_master_ctrl_if #(
   parameter int DIV_W = 32
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       i2c_ctrl;
   logic [DIV_W-1:0] i2c_bitrate;
   logic [7:0]       i2c_data_out;
   logic [7:0]       i2c_data_in;
   logic             ack_err;
   logic             busy;
   logic             done;
   logic             scl_oe;
   logic             sda_oe;
   logic             scl_in;
   logic             sda_in;

   modport master (
      output cmd_valid, i2c_ctrl, i2c_bitrate,
      output i2c_data_out, scl_in, sda_in,
      input  cmd_ready, i2c_data_in, ack_err,
      input  busy, done, scl_oe, sda_oe
   );

   modport slave (
      input  cmd_valid, i2c_ctrl, i2c_bitrate,
      input  i2c_data_out, scl_in, sda_in,
      output cmd_ready, i2c_data_in, ack_err,
      output busy, done, scl_oe, sda_oe
   );

endinterface

// File: rtl/i2c_clk_div.sv
// Quarter-period tick generator; the count freezes while
// hold is high so a stretched SCL extends the phase.
module i2c_clk_div #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             hold,
   input  logic [DIV_W-1:0] period,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (!enable) begin
         cnt_d = '0;
      end else if (!hold) begin
         if (cnt_q == period) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master byte engine: sequences START/BIT/ACK/STOP in
// quarter-period phases and drives open-drain SCL/SDA enables.
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int DIV_W = 32
) (
   input logic              clk,
   input logic              rst,
   i2c_master_ctrl_if.slave bus
);

   state_t           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [4:0]       ctrl_q, ctrl_d;
   logic [7:0]       sreg_q, sreg_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       data_in_q, data_in_d;
   logic             nack_q, nack_d;
   logic             ack_err_q, ack_err_d;
   logic             scl_q, scl_d;
   logic             sda_q, sda_d;
   logic             tick, wr, rd, xfer;
   logic             unused_ctrl;

   assign wr   = ctrl_q[CTRL_WRITE];
   assign rd   = ctrl_q[CTRL_READ] & ~wr;
   assign xfer = wr | ctrl_q[CTRL_READ];
   assign unused_ctrl = ^{bus.i2c_ctrl[7:5], ctrl_q[CTRL_START]};

   i2c_clk_div #(.DIV_W(DIV_W)) u_div (
      .clk    (clk),
      .rst    (rst),
      .enable (state_q != ST_IDLE),
      .hold   (~scl_q & ~bus.scl_in),
      .period (div_q),
      .tick   (tick)
   );

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      bit_cnt_d = bit_cnt_q;
      ctrl_d    = ctrl_q;
      sreg_d    = sreg_q;
      div_d     = div_q;
      data_in_d = data_in_q;
      nack_d    = nack_q;
      ack_err_d = ack_err_q;
      scl_d     = scl_q;
      sda_d     = sda_q;
      unique case (state_q)
         ST_IDLE: if (bus.cmd_valid) begin
            ctrl_d    = bus.i2c_ctrl[4:0];
            sreg_d    = bus.i2c_data_out;
            div_d     = bus.i2c_bitrate;
            nack_d    = 1'b0;
            phase_d   = 2'd0;
            bit_cnt_d = 3'd0;
            if (bus.i2c_ctrl[CTRL_WRITE]) ack_err_d = 1'b0;
            if (bus.i2c_ctrl[CTRL_START])
               state_d = ST_START;
            else if (bus.i2c_ctrl[CTRL_WRITE] | bus.i2c_ctrl[CTRL_READ])
               state_d = ST_BIT;
            else if (bus.i2c_ctrl[CTRL_STOP])
               state_d = ST_STOP;
            else
               state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (wr) ack_err_d = nack_q;
            if (rd) data_in_d = sreg_q;
         end
         default: if (tick) begin
            phase_d = phase_q + 2'd1;
            // SDA is sampled mid-high, at the q1->q2 boundary
            if (phase_q == 2'd1) begin
               if (state_q == ST_BIT && rd)
                  sreg_d = {sreg_q[6:0], bus.sda_in};
               if (state_q == ST_ACK && wr)
                  nack_d = bus.sda_in;
            end
            if (phase_q == 2'd3) begin
               unique case (state_q)
                  ST_START:
                     state_d = xfer ? ST_BIT :
                               ctrl_q[CTRL_STOP] ? ST_STOP : ST_DONE;
                  ST_BIT: begin
                     if (wr) sreg_d = {sreg_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) state_d = ST_ACK;
                  end
                  ST_ACK:
                     state_d = ctrl_q[CTRL_STOP] ? ST_STOP : ST_DONE;
                  default:
                     state_d = ST_DONE;
               endcase
            end
         end
      endcase
      // Line drives are set on entry to each new phase
      if (state_d != state_q || phase_d != phase_q) begin
         unique case (state_d)
            ST_START:
               unique case (phase_d)
                  2'd0:    sda_d = 1'b0;
                  2'd1:    scl_d = 1'b0;
                  2'd2:    sda_d = 1'b1;
                  default: scl_d = 1'b1;
               endcase
            ST_BIT:
               if (phase_d == 2'd0) begin
                  scl_d = 1'b1;
                  sda_d = ctrl_d[CTRL_WRITE] & ~sreg_d[7];
               end else begin
                  scl_d = (phase_d == 2'd3);
               end
            ST_ACK:
               if (phase_d == 2'd0) begin
                  scl_d = 1'b1;
                  sda_d = ~ctrl_d[CTRL_WRITE] & ~ctrl_d[CTRL_NACK];
               end else begin
                  scl_d = (phase_d == 2'd3);
               end
            ST_STOP:
               unique case (phase_d)
                  2'd0:    sda_d = 1'b1;
                  2'd1:    scl_d = 1'b0;
                  2'd2:    sda_d = 1'b0;
                  default: ;
               endcase
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         phase_q   <= 2'd0;
         bit_cnt_q <= 3'd0;
         ctrl_q    <= '0;
         sreg_q    <= '0;
         div_q     <= '0;
         data_in_q <= '0;
         nack_q    <= 1'b0;
         ack_err_q <= 1'b0;
         scl_q     <= 1'b0;
         sda_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         bit_cnt_q <= bit_cnt_d;
         ctrl_q    <= ctrl_d;
         sreg_q    <= sreg_d;
         div_q     <= div_d;
         data_in_q <= data_in_d;
         nack_q    <= nack_d;
         ack_err_q <= ack_err_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
      end
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.i2c_data_in = data_in_q;
   assign bus.ack_err     = ack_err_q;
   assign bus.scl_oe      = scl_q;
   assign bus.sda_oe      = sda_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural slave
// and a scoreboard of expected SDA values per SCL pulse.
module tb_i2c_master_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   int   done_total = 0;
   int   rise_n = 0;
   int   cyc = 0;
   int   last_rel = -1;
   int   st_cnt = 0;
   logic busy_p = 1'b0;
   logic oe_p = 1'b0;
   logic scl_p = 1'b1;
   logic slv_sda_low = 1'b0;
   logic slv_scl_low = 1'b0;
   logic slv_read = 1'b0;
   logic slv_ack = 1'b1;
   logic stretch_en = 1'b0;
   logic [7:0] slv_byte = 8'h00;
   logic exp_sda[$];
   logic obs_sda[$];
   int   ivl[$];

   i2c_master_ctrl_if #(.DIV_W(32)) bus ();

   i2c_master_ctrl #(.DIV_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.scl_in = ~bus.scl_oe & ~slv_scl_low;
   assign bus.sda_in = ~bus.sda_oe & ~slv_sda_low;

   // slave model and bus monitor
   always @(negedge clk) begin
      logic sl, sd;
      cyc++;
      if (bus.done) done_total++;
      if (bus.busy && !busy_p) begin
         rise_n = 0;
         last_rel = -1;
         st_cnt = 0;
         slv_sda_low = 1'b0;
         slv_scl_low = 1'b0;
         obs_sda.delete();
         ivl.delete();
      end
      if (bus.scl_oe && !oe_p) begin
         rise_n++;
         if (slv_read && rise_n >= 1 && rise_n <= 8)
            slv_sda_low = !slv_byte[8-rise_n];
         else if (!slv_read && rise_n == 9)
            slv_sda_low = slv_ack;
         else
            slv_sda_low = 1'b0;
         if (stretch_en && rise_n == 4) slv_scl_low = 1'b1;
      end
      if (!bus.scl_oe && oe_p) begin
         if (last_rel >= 0) ivl.push_back(cyc - last_rel);
         last_rel = cyc;
      end
      if (slv_scl_low && !bus.scl_oe) begin
         if (st_cnt == 20) slv_scl_low = 1'b0;
         else st_cnt++;
      end
      sl = !bus.scl_oe && !slv_scl_low;
      sd = !bus.sda_oe && !slv_sda_low;
      if (sl && !scl_p) obs_sda.push_back(sd);
      busy_p = bus.busy;
      oe_p = bus.scl_oe;
      scl_p = sl;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] b, input logic ack);
      for (int i = 7; i >= 0; i--) exp_sda.push_back(b[i]);
      exp_sda.push_back(ack);
      exp_sda.push_back(1'b0);
   endtask

   task automatic check_sda(input string tag);
      int n;
      n = obs_sda.size();
      chk({tag, "_npulse"}, n, exp_sda.size());
      for (int i = 0; exp_sda.size() > 0; i++) begin
         logic e, o;
         e = exp_sda.pop_front();
         o = (i < n) ? obs_sda[i] : 1'bx;
         chk($sformatf("%s_sda%0d", tag, i), o, e);
      end
   endtask

   task automatic check_ivl(input string tag, input int exp,
                            input int sidx, input int sval);
      chk({tag, "_nivl"}, ivl.size(), 9);
      for (int i = 0; i < ivl.size(); i++)
         chk($sformatf("%s_ivl%0d", tag, i), ivl[i],
             (i == sidx) ? sval : exp);
   endtask

   task automatic issue(input logic [7:0] ctrl, input logic [31:0] br,
                        input logic [7:0] data);
      @(negedge clk);
      bus.i2c_ctrl = ctrl;
      bus.i2c_bitrate = br;
      bus.i2c_data_out = data;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.i2c_ctrl = 8'h08;
      bus.i2c_bitrate = 32'd7;
      bus.i2c_data_out = ~data;
      chk("accept_busy", bus.busy, 1'b1);
      chk("accept_ready", bus.cmd_ready, 1'b0);
   endtask

   task automatic wait_done(input string tag, input int base);
      int n;
      n = 0;
      while (done_total == base && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({tag, "_done_seen"}, done_total != base, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      chk({tag, "_done_once"}, done_total - base, 1);
      chk({tag, "_scl_rel"}, bus.scl_oe, 1'b0);
      chk({tag, "_sda_rel"}, bus.sda_oe, 1'b0);
      chk({tag, "_idle"}, bus.cmd_ready, 1'b1);
   endtask

   initial begin
      int base, n;
      bus.cmd_valid = 1'b0;
      bus.i2c_ctrl = 8'h00;
      bus.i2c_bitrate = 32'd0;
      bus.i2c_data_out = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", bus.cmd_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_scl", bus.scl_oe, 1'b0);
      chk("rst_sda", bus.sda_oe, 1'b0);
      chk("rst_ackerr", bus.ack_err, 1'b0);
      chk("rst_din", bus.i2c_data_in, 8'h00);

      // write 0xA5, slave ACKs, bitrate 3
      slv_read = 1'b0;
      slv_ack = 1'b1;
      push_exp(8'hA5, 1'b0);
      base = done_total;
      issue(8'h07, 32'd3, 8'hA5);
      wait_done("wr_a5", base);
      chk("wr_a5_ackerr", bus.ack_err, 1'b0);
      check_sda("wr_a5");
      check_ivl("wr_a5", 16, -1, 0);

      // read 0x3C with NACK_SEND, bitrate 1
      slv_read = 1'b1;
      slv_byte = 8'h3C;
      push_exp(8'h3C, 1'b1);
      base = done_total;
      issue(8'h1B, 32'd1, 8'h00);
      wait_done("rd_3c", base);
      chk("rd_3c_din", bus.i2c_data_in, 8'h3C);
      check_sda("rd_3c");
      check_ivl("rd_3c", 8, -1, 0);

      // write 0x55, slave NACKs, STOP still issued
      slv_read = 1'b0;
      slv_ack = 1'b0;
      push_exp(8'h55, 1'b1);
      base = done_total;
      issue(8'h07, 32'd1, 8'h55);
      wait_done("wr_nack", base);
      chk("wr_nack_ackerr", bus.ack_err, 1'b1);
      check_sda("wr_nack");

      // slave stretches SCL 20 cycles at bit 3
      slv_ack = 1'b1;
      stretch_en = 1'b1;
      push_exp(8'hC3, 1'b0);
      base = done_total;
      issue(8'h07, 32'd3, 8'hC3);
      wait_done("stretch", base);
      stretch_en = 1'b0;
      chk("stretch_ackerr", bus.ack_err, 1'b0);
      chk("stretch_din", bus.i2c_data_in, 8'h3C);
      check_sda("stretch");
      check_ivl("stretch", 16, 3, 36);

      // reset in the middle of bit 4
      base = done_total;
      issue(8'h07, 32'd1, 8'h81);
      n = 0;
      while (rise_n < 6 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("abort_reached", rise_n >= 6, 1'b1);
      chk("abort_pre_scl", bus.scl_oe, 1'b1);
      chk("abort_pre_sda", bus.sda_oe, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_scl", bus.scl_oe, 1'b0);
      chk("abort_sda", bus.sda_oe, 1'b0);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      chk("abort_din", bus.i2c_data_in, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("abort_no_done", done_total - base, 0);
      chk("abort_ready", bus.cmd_ready, 1'b1);

      // bitrate 0 write with a stray command while busy
      push_exp(8'h96, 1'b0);
      base = done_total;
      issue(8'h07, 32'd0, 8'h96);
      repeat (10) @(negedge clk);
      #1;
      chk("stray_ready", bus.cmd_ready, 1'b0);
      bus.i2c_ctrl = 8'h07;
      bus.i2c_data_out = 8'h00;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_done("br0", base);
      chk("br0_ackerr", bus.ack_err, 1'b0);
      check_sda("br0");
      check_ivl("br0", 4, -1, 0);
      repeat (80) @(negedge clk);
      #1;
      chk("stray_one_done", done_total - base, 1);
      chk("stray_busy", bus.busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter: DIV_W, 32, width of bitrate/divider value.
REQ-002 SHALL have ports (clock and reset first):
  clk  in  1  system clock, all logic rising-edge.
  rst  in  1  reset, asynchronous, active-high.
  cmd_valid  in  1  command strobe from register block.
  cmd_ready  out  1  high when IDLE; command accepted on cmd_valid && cmd_ready.
  i2c_ctrl  in  8  command bits: [0] START, [1] STOP, [2] WRITE, [3] READ, [4] NACK_SEND; others ignored.
  i2c_bitrate  in  DIV_W  quarter-period length minus one, in clk cycles.
  i2c_data_out  in  8  byte to transmit, MSB first.
  i2c_data_in  out  8  last received byte.
  ack_err  out  1  slave NACKed the last written byte.
  busy  out  1  high from command accept until done.
  done  out  1  one-cycle pulse when command completes.
  scl_oe  out  1  1 = drive SCL low, 0 = release.
  sda_oe  out  1  1 = drive SDA low, 0 = release.
  scl_in  in  1  sampled SCL (stretching detection).
  sda_in  in  1  sampled SDA.

Function
REQ-003 SHALL latch i2c_ctrl, i2c_data_out and i2c_bitrate on accept; later changes SHALL NOT affect the running command.
REQ-004 SHALL generate a quarter tick every (bitrate+1) clk cycles while not IDLE; bitrate 0 gives a tick every cycle.
REQ-005 SHALL run FSM states IDLE, START, BIT, ACK, STOP, DONE; each phase lasts one quarter period; each state has 4 phases (q0..q3).
REQ-006 Accept: START set -> START; else WRITE or READ set -> BIT; else STOP set -> STOP; else DONE.
REQ-007 START q0: release SDA; q1: release SCL; q2: drive SDA low; q3: drive SCL low; then BIT if WRITE|READ, else STOP if STOP set, else DONE. This also produces a repeated start when SCL is held low.
REQ-008 WRITE SHALL take precedence if WRITE and READ are both set.
REQ-009 BIT, 8 iterations MSB first, 3-bit counter: q0 SCL low, set SDA (write: sda_oe = ~bit; read: release); q1, q2 SCL released; q3 SCL low.
REQ-010 In read, SHALL sample sda_in into the shift register at the q1->q2 boundary.
REQ-011 ACK: same phases as BIT; write: SDA released, sample sda_in at q1->q2 into ack_err (1 = NACK); read: sda_oe = ~NACK_SEND.
REQ-012 After ACK: STOP if STOP set, else DONE with SCL held low (bus kept).
REQ-013 STOP q0: drive SDA low; q1: release SCL; q2: release SDA; q3: idle hold; then DONE.
REQ-014 Clock stretching: in any phase where SCL is released, the quarter counter SHALL hold while scl_in = 0 and resume when scl_in = 1.
REQ-015 DONE SHALL last one cycle: done = 1, update i2c_data_in (read) and ack_err (write), then go to IDLE.
REQ-016 In IDLE, cmd_ready = 1 and busy = 0; cmd_valid while busy SHALL be ignored (not queued).
REQ-017 ack_err SHALL be cleared on accepting a WRITE command; i2c_data_in SHALL hold until the next completed READ.

Reset
REQ-018 On rst: FSM IDLE; scl_oe = 0, sda_oe = 0, busy = 0, done = 0, ack_err = 0, i2c_data_in = 0x00, all counters 0.
REQ-019 rst asserted mid-command SHALL release both lines immediately (asynchronously) and abort with no done pulse.

Structure
REQ-020 A shared package i2c_pkg SHALL hold the ctrl bit-position constants and the FSM state enum.
REQ-021 The quarter-period tick generator SHALL be a sub-module i2c_clk_div (inputs: enable, hold, period; output: tick).

Verification
REQ-022 Bitrate 3, ctrl START|WRITE|STOP (0x07), data 0xA5, slave ACKs -> 9 SCL pulses of 16 clk each; SDA bits 1,0,1,0,0,1,0,1; ack_err = 0; done once.
REQ-023 Bitrate 1, ctrl START|READ|STOP|NACK_SEND (0x1B), slave drives 0x3C -> i2c_data_in = 0x3C; SDA released during 9th pulse.
REQ-024 Write 0x55, slave leaves SDA high at ACK -> ack_err = 1, STOP still issued.
REQ-025 Slave holds SCL low 20 cycles at bit 3 q1 -> phase extended by exactly 20 cycles; data correct.
REQ-026 rst pulse at bit 4 of a write -> scl_oe = sda_oe = 0 immediately, busy = 0, no done; next command runs normally.
REQ-027 cmd_valid pulsed while busy -> ignored; one done only; bitrate 0 write -> 4-cycle bit period.
